fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_controller.sv | 114 +++++++++++
 tb/tb_fetch_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if : fetch controller control, memory and decode handshake bundle
// Revision : 1.0
// ============================================================================
interface fetch_if;
  logic        start;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  modport master (
    input  start, redirect, redirect_target, imem_instruction, out_ready,
    output imem_address, out_valid, out_instruction, out_pc, halted, fault, fetch_count
  );

  modport slave (
    output start, redirect, redirect_target, imem_instruction, out_ready,
    input  imem_address, out_valid, out_instruction, out_pc, halted, fault, fetch_count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : sequential instruction fetch into a 2-entry decode buffer
// Revision : 1.0
// ============================================================================
module fetch_controller #(
  parameter int          MEM_WORDS = 174,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_FETCH     = 2'd1;
  localparam logic [1:0]  S_HALT      = 2'd2;
  localparam logic [1:0]  S_FAULT     = 2'd3;
  localparam logic [31:0] C_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr0, r_instr1;
  logic [31:0] r_pc0, r_pc1;
  logic [1:0]  r_count;
  logic [15:0] r_fetch_count;

  logic        w_pop;
  logic        w_fetching;
  logic        w_bad_addr;
  logic        w_fault;
  logic        w_halt;
  logic        w_push;
  logic        w_redirect;
  logic [1:0]  w_slot;

  assign w_pop      = (r_count != 2'd0) && bus.out_ready;
  // Redirect outranks every fetch-side event, so it masks them all here.
  assign w_fetching = (r_state == S_FETCH) && !bus.redirect;
  assign w_bad_addr = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= C_MEM_WORDS);
  assign w_fault    = w_fetching && w_bad_addr;
  assign w_halt     = w_fetching && !w_bad_addr && (bus.imem_instruction == HALT_WORD);
  assign w_push     = w_fetching && !w_bad_addr && (bus.imem_instruction != HALT_WORD)
                      && ((r_count != 2'd2) || w_pop);
  assign w_redirect = bus.redirect && ((r_state == S_FETCH) || (r_state == S_HALT));
  // Slot the new entry lands in once this cycle's pop has shifted the buffer.
  assign w_slot     = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_count <= 16'd0;
    end else begin
      r_fetch_count <= r_fetch_count + {15'd0, w_push};
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
          end
        end
        S_FETCH: begin
          if (w_fault)      r_state <= S_FAULT;
          else if (w_halt)  r_state <= S_HALT;
          else if (w_push)  r_pc    <= r_pc + 32'd4;
        end
        default: ;
      endcase
      if (w_redirect) begin
        r_state <= S_FETCH;
        r_pc    <= bus.redirect_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_instr0 <= 32'd0;
      r_instr1 <= 32'd0;
      r_pc0    <= 32'd0;
      r_pc1    <= 32'd0;
    end else if (w_redirect) begin
      r_count <= 2'd0;
    end else begin
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) begin
        r_instr0 <= r_instr1;
        r_pc0    <= r_pc1;
      end
      if (w_push) begin
        if (w_slot == 2'd0) begin
          r_instr0 <= bus.imem_instruction;
          r_pc0    <= r_pc;
        end else begin
          r_instr1 <= bus.imem_instruction;
          r_pc1    <= r_pc;
        end
      end
    end
  end

  assign bus.imem_address    = r_pc;
  assign bus.out_valid       = (r_count != 2'd0);
  assign bus.out_instruction = r_instr0;
  assign bus.out_pc          = r_pc0;
  assign bus.halted          = (r_state == S_HALT) && (r_count == 2'd0);
  assign bus.fault           = (r_state == S_FAULT);
  assign bus.fetch_count     = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// tb_fetch_controller : directed self-checking bench for fetch_controller
// Revision : 1.0
// ============================================================================
module tb_fetch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] mem [0:1023];

  fetch_if bus ();

  fetch_controller #(.MEM_WORDS(174), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  assign bus.imem_instruction = mem[bus.imem_address[11:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect = 1'b1;
    bus.redirect_target = target;
    tick();
    bus.redirect = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0; bus.out_ready = 1'b0;
    init_mem();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.out_instruction); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.out_pc); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
    checks++; if (bus.fetch_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", bus.fetch_count); end
    checks++; if (bus.imem_address !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_address); end
  endtask

  task automatic test_stream_to_halt();
    do_reset();
    init_mem();
    for (int i = 0; i < 4; i++) mem[i] = 32'h2001_0001 + i;
    mem[4] = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    pulse_start();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL start_valid got=%b exp=0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i))
        begin failures++; $display("FAIL stream_pc[%0d] got=%h/%b exp=%h/1", i, bus.out_pc, bus.out_valid, 4 * i); end
      checks++; if (bus.out_instruction !== 32'h2001_0001 + 32'(i))
        begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.out_instruction, 32'h2001_0001 + i); end
    end
    tick();
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", bus.halted); end
    checks++; if (bus.fetch_count !== 16'd4) begin failures++; $display("FAIL halt_count got=%0d exp=4", bus.fetch_count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    init_mem();
    pulse_start();
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.imem_address !== 32'h8) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=8", i, bus.imem_address); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instruction !== 32'h1000_0000)
        begin failures++; $display("FAIL stall_head[%0d] got=%h/%h exp=0/10000000", i, bus.out_pc, bus.out_instruction); end
    end
    checks++; if (bus.fetch_count !== 16'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", bus.fetch_count); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++; if (bus.out_pc !== 32'(4 * i) || bus.out_instruction !== 32'h1000_0000 + 32'(i))
        begin failures++; $display("FAIL drain_head[%0d] got=%h/%h exp=%h", i, bus.out_pc, bus.out_instruction, 4 * i); end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    init_mem();
    pulse_start();
    tick();
    tick();
    do_redirect(32'h40);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_address !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h exp=40", bus.imem_address); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instruction !== 32'h1000_0010)
      begin failures++; $display("FAIL redir_first got=%h/%h exp=40/10000010", bus.out_pc, bus.out_instruction); end
    tick();
    checks++; if (bus.out_pc !== 32'h44) begin failures++; $display("FAIL redir_second got=%h exp=44", bus.out_pc); end
  endtask

  task automatic test_fault();
    do_redirect(32'h2B8);
    tick();
    checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL range_fault got=%b exp=1", bus.fault); end
    checks++; if (bus.fetch_count !== 16'd4) begin failures++; $display("FAIL range_count got=%0d exp=4", bus.fetch_count); end
    do_redirect(32'h40);
    tick();
    checks++; if (bus.fault !== 1'b1 || bus.imem_address !== 32'h2B8)
      begin failures++; $display("FAIL fault_sticky got=%b/%h exp=1/2b8", bus.fault, bus.imem_address); end
    checks++; if (bus.out_valid !== 1'b0 || bus.fetch_count !== 16'd4)
      begin failures++; $display("FAIL fault_nopush got=%b/%0d exp=0/4", bus.out_valid, bus.fetch_count); end
    do_reset();
    pulse_start();
    do_redirect(32'h42);
    tick();
    checks++; if (bus.fault !== 1'b1) begin failures++; $display("FAIL align_fault got=%b exp=1", bus.fault); end
    checks++; if (bus.fetch_count !== 16'd0) begin failures++; $display("FAIL align_count got=%0d exp=0", bus.fetch_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    init_mem();
    pulse_start();
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.fetch_count !== 16'd2)
      begin failures++; $display("FAIL pre_rst got=%b/%0d exp=1/2", bus.out_valid, bus.fetch_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fault !== 1'b0 || bus.halted !== 1'b0)
      begin failures++; $display("FAIL async_flags got=%b%b%b exp=000", bus.out_valid, bus.fault, bus.halted); end
    checks++; if (bus.fetch_count !== 16'd0 || bus.imem_address !== 32'h0)
      begin failures++; $display("FAIL async_count got=%0d/%h exp=0/0", bus.fetch_count, bus.imem_address); end
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fetch_count !== 16'd0)
      begin failures++; $display("FAIL post_rst_idle got=%b/%0d exp=0/0", bus.out_valid, bus.fetch_count); end
  endtask

  task automatic test_halt_redirect();
    do_reset();
    init_mem();
    mem[2] = 32'hFFFF_FFFF;
    bus.out_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    tick();
    checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt2_flag got=%b exp=1", bus.halted); end
    checks++; if (bus.fetch_count !== 16'd2) begin failures++; $display("FAIL halt2_count got=%0d exp=2", bus.fetch_count); end
    tick();
    checks++; if (bus.halted !== 1'b1 || bus.imem_address !== 32'h8)
      begin failures++; $display("FAIL halt2_hold got=%b/%h exp=1/8", bus.halted, bus.imem_address); end
    do_redirect(32'h10);
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%b exp=0", bus.halted); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out_instruction !== 32'h1000_0004)
      begin failures++; $display("FAIL resume_head got=%h/%h exp=10/10000004", bus.out_pc, bus.out_instruction); end
  endtask

  initial begin
    test_reset();
    test_stream_to_halt();
    test_backpressure();
    test_redirect_flush();
    test_fault();
    test_async_reset();
    test_halt_redirect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
